mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- CPU-side initiator for the data port of the on-chip dual-port memory.
- Accepts byte and 16-bit word load/store requests from the core over a valid/ready handshake.
- Breaks each request into byte accesses on the 8-bit memory data port, honouring the memory's one-cycle read latency and its registered read-modify-write store path.
- Returns load data (little-endian, optional sign extension) and a completion pulse.

Parameters:
- none

Ports:
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (combinational, high only in IDLE)
- req_write  in  1  1 = store, 0 = load
- req_size  in  1  0 = byte, 1 = word
- req_signed  in  1  sign-extend byte loads; ignored for words and stores
- req_addr  in  16  byte address
- req_wdata  in  16  store data; byte store uses [7:0]
- resp_valid  out  1  one-cycle completion pulse, loads and stores
- resp_rdata  out  16  load result; held until next load completes
- mem_addr  out  16  memory data-port byte address (registered)
- mem_wdata  out  8  memory data-port write byte (registered)
- mem_write  out  1  memory data-port write strobe (registered)
- mem_rdata  in  8  memory data-port read byte

Behaviour:
- Memory timing contract:
  - mem_addr presented in cycle N gives valid mem_rdata in cycle N+1 while mem_addr is still held.
  - A store byte needs three cycles with mem_addr stable: SETUP (write=0), STROBE (write=1), COMMIT (write=0).
  - mem_addr must not change between SETUP and end of COMMIT.
- Reset values: state IDLE; mem_addr 0, mem_wdata 0, mem_write 0, resp_valid 0, resp_rdata 0, byte index 0.
- Request accepted on the rising edge with req_valid && req_ready. Addr, size, write, signed and wdata are latched; later changes on req_* are ignored.
- States and transitions:
  - IDLE: on accept, load mem_addr = req_addr, idx = 0. Go to RD_ADDR (load) or WR_SETUP (store).
  - RD_ADDR -> RD_DATA.
  - RD_DATA: capture mem_rdata into byte idx.
    - If word and idx = 0: idx = 1, mem_addr += 1, go to RD_ADDR.
    - Else go to IDLE with resp_valid = 1 and resp_rdata updated.
  - WR_SETUP: mem_wdata = data byte idx. Go to WR_STROBE.
  - WR_STROBE: mem_write = 1 during this state only. Go to WR_COMMIT.
  - WR_COMMIT:
    - If word and idx = 0: idx = 1, mem_addr += 1, go to WR_SETUP.
    - Else go to IDLE with resp_valid = 1.
- Word layout: low byte at addr, high byte at addr+1 (little-endian). Odd addresses allowed: the second byte goes to the next word. Address increment wraps 0xFFFF -> 0x0000.
- Byte load result: {8{b[7]}} when signed, else 8'h00, concatenated with the byte.
- Latency from accept edge (cycle 0) to resp_valid:
  - byte load: cycle 3
  - word load: cycle 5
  - byte store: cycle 4
  - word store: cycle 7
- req_ready is high in the resp_valid cycle, so back-to-back requests incur no extra bubble.
- Stores to addresses >= 0x8000 run the full sequence. Memory ignores them; the unit still pulses resp_valid.
- Reset mid-operation: return to IDLE next edge, mem_write drops to 0, no resp_valid for the aborted request. A store byte already past STROBE may have committed.
- mem_write is never high outside WR_STROBE. Two store bytes are always separated by a COMMIT and a SETUP cycle.

Test Plan:
- Byte store 0xA5 to 0x0010, then byte load unsigned from 0x0010 -> store resp at cycle 4, load resp_rdata = 0x00A5; mem_write high exactly 1 cycle.
- Preload word 0x1234 at 0x0020; byte store 0xFF to 0x0021; word load 0x0020 -> resp_rdata = 0xFF34 (low byte preserved by RMW).
- Word store 0xBEEF at odd address 0x0031; word load 0x0031 -> 0xBEEF; byte loads: 0x0031 -> 0x00EF, 0x0032 -> 0x00BE, 0x0030 unchanged.
- Byte 0x80 at 0x0040: signed byte load -> 0xFF80, unsigned -> 0x0080. Word store at 0xFFFF -> second write at mem_addr 0x0000.
- Back-to-back: hold req_valid with two byte loads -> second accepted in first's resp_valid cycle; resp pulses 3 cycles apart. req_* changed mid-operation has no effect.
- Assert reset during WR_SETUP of a word store -> mem_write never asserts, no resp_valid, req_ready high the cycle after reset deasserts, all outputs at reset values.

Source files
------------

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : CPU-side initiator for the 8-bit data port of the on-chip
//            dual-port memory. Takes byte / 16-bit word load and store
//            requests over a valid/ready handshake, splits them into byte
//            accesses (little-endian, second byte at addr+1 with 16-bit
//            wrap), and returns load data plus a one-cycle completion pulse.
// Ports    : clock, reset         - clock, synchronous active-high reset
//            req_valid/req_ready  - request handshake (ready only in IDLE)
//            req_write, req_size  - store/load, byte/word
//            req_signed           - sign-extend byte loads
//            req_addr, req_wdata  - byte address, store data
//            resp_valid           - completion pulse (loads and stores)
//            resp_rdata           - last load result, held between loads
//            mem_addr, mem_wdata,
//            mem_write, mem_rdata - memory data port (outputs registered)
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_size,
    input  logic        req_signed,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_write,
    input  logic [7:0]  mem_rdata
);

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_rd_addr   = 3'd1;
    localparam logic [2:0] c_st_rd_data   = 3'd2;
    localparam logic [2:0] c_st_wr_setup  = 3'd3;
    localparam logic [2:0] c_st_wr_strobe = 3'd4;
    localparam logic [2:0] c_st_wr_commit = 3'd5;

    logic [2:0]  r_state;
    logic        r_idx;
    logic        r_size;
    logic        r_signed;
    logic [15:0] r_wdata;
    logic [7:0]  r_rdata_lo;
    logic [15:0] r_mem_addr;
    logic [7:0]  r_mem_wdata;
    logic        r_mem_write;
    logic        r_resp_valid;
    logic [15:0] r_resp_rdata;

    logic        w_accept;
    logic        w_second_byte;
    logic [15:0] w_addr_inc;
    logic [7:0]  w_ext;

    assign req_ready     = (r_state == c_st_idle);
    assign w_accept      = req_valid && req_ready;
    // A word needs a second pass only after its low byte (idx 0).
    assign w_second_byte = r_size && !r_idx;
    // 16-bit add wraps 0xFFFF -> 0x0000 naturally.
    assign w_addr_inc    = r_mem_addr + 16'd1;
    assign w_ext         = (r_signed && mem_rdata[7]) ? 8'hFF : 8'h00;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_idx        <= 1'b0;
            r_size       <= 1'b0;
            r_signed     <= 1'b0;
            r_wdata      <= 16'h0000;
            r_rdata_lo   <= 8'h00;
            r_mem_addr   <= 16'h0000;
            r_mem_wdata  <= 8'h00;
            r_mem_write  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 16'h0000;
        end else begin
            // Strobe and completion are single-cycle unless a state re-asserts them.
            r_mem_write  <= 1'b0;
            r_resp_valid <= 1'b0;

            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_mem_addr <= req_addr;
                        r_idx      <= 1'b0;
                        r_size     <= req_size;
                        r_signed   <= req_signed;
                        r_wdata    <= req_wdata;
                        r_state    <= req_write ? c_st_wr_setup : c_st_rd_addr;
                    end
                end

                c_st_rd_addr: begin
                    // Address has been on the port one cycle; data arrives next.
                    r_state <= c_st_rd_data;
                end

                c_st_rd_data: begin
                    if (w_second_byte) begin
                        r_rdata_lo <= mem_rdata;
                        r_idx      <= 1'b1;
                        r_mem_addr <= w_addr_inc;
                        r_state    <= c_st_rd_addr;
                    end else begin
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= r_size ? {mem_rdata, r_rdata_lo}
                                               : {w_ext, mem_rdata};
                        r_state      <= c_st_idle;
                    end
                end

                c_st_wr_setup: begin
                    r_mem_wdata <= r_idx ? r_wdata[15:8] : r_wdata[7:0];
                    r_mem_write <= 1'b1;
                    r_state     <= c_st_wr_strobe;
                end

                c_st_wr_strobe: begin
                    // mem_write falls via the default; address stays put for COMMIT.
                    r_state <= c_st_wr_commit;
                end

                c_st_wr_commit: begin
                    if (w_second_byte) begin
                        r_idx      <= 1'b1;
                        r_mem_addr <= w_addr_inc;
                        r_state    <= c_st_wr_setup;
                    end else begin
                        r_resp_valid <= 1'b1;
                        r_state      <= c_st_idle;
                    end
                end

                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_write  = r_mem_write;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Directed self-checking bench for mem_access_unit, with a
//            behavioural memory (one-cycle read latency, stores above
//            0x7FFF ignored).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_size;
    logic        req_signed;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_write;
    logic [7:0]  mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_unit u_dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural memory.
    logic [7:0]  r_mem [0:65535] = '{default: 8'h00};
    int          r_wr_count = 0;
    logic [15:0] r_last_wr_addr = 16'h0000;
    logic        r_prev_write = 1'b0;

    always @(posedge clock) begin
        mem_rdata <= r_mem[mem_addr];
        if (mem_write && (mem_addr < 16'h8000))
            r_mem[mem_addr] <= mem_wdata;
        if (mem_write) begin
            r_wr_count     <= r_wr_count + 1;
            r_last_wr_addr <= mem_addr;
        end
        r_prev_write <= mem_write;
    end

    task automatic check_value(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Strobe must never be high on two consecutive cycles.
    always @(negedge clock) begin
        if (mem_write && !reset)
            check_value("wr_pulse_single", 32'(r_prev_write), 32'd0);
    end

    // One complete request; checks latency, strobe count, resp data, pulse width.
    task automatic do_op(input string tag, input logic wr, input logic sz,
                         input logic sg, input logic [15:0] addr,
                         input logic [15:0] wd, input int exp_lat,
                         input logic [15:0] exp_rdata);
        int n;
        int w0;
        @(negedge clock);
        check_value({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        w0 = r_wr_count;
        @(posedge clock); #1;
        // Scramble request inputs: the latched copy must be what gets used.
        req_valid  = 1'b0;
        req_write  = ~wr;
        req_size   = ~sz;
        req_signed = ~sg;
        req_addr   = ~addr;
        req_wdata  = ~wd;
        n = 1;
        while (!resp_valid && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        check_value({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check_value({tag, "_rdata"}, 32'(resp_rdata), 32'(exp_rdata));
        check_value({tag, "_wr_count"}, 32'(r_wr_count - w0),
                    wr ? (sz ? 32'd2 : 32'd1) : 32'd0);
        @(posedge clock); #1;
        check_value({tag, "_resp_pulse"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        int w0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 1'b0;
        req_signed = 1'b0;
        req_addr   = 16'h0000;
        req_wdata  = 16'h0000;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check_value("rst_ready",      32'(req_ready),  32'd1);
        check_value("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_value("rst_resp_rdata", 32'(resp_rdata), 32'd0);
        check_value("rst_mem_addr",   32'(mem_addr),   32'd0);
        check_value("rst_mem_wdata",  32'(mem_wdata),  32'd0);
        check_value("rst_mem_write",  32'(mem_write),  32'd0);

        // Byte store then unsigned byte load.
        do_op("st_b_10", 1, 0, 0, 16'h0010, 16'h33A5, 4, 16'h0000);
        do_op("ld_b_10", 0, 0, 0, 16'h0010, 16'h0000, 3, 16'h00A5);

        // Word 0x1234 at 0x20, overwrite high byte; stores leave resp_rdata alone.
        do_op("st_b_20", 1, 0, 0, 16'h0020, 16'h0034, 4, 16'h00A5);
        do_op("st_b_21", 1, 0, 0, 16'h0021, 16'h0012, 4, 16'h00A5);
        do_op("st_b_21f", 1, 0, 0, 16'h0021, 16'h00FF, 4, 16'h00A5);
        do_op("ld_w_20", 0, 1, 0, 16'h0020, 16'h0000, 5, 16'hFF34);

        // Odd-address word store.
        do_op("st_b_30", 1, 0, 0, 16'h0030, 16'h005A, 4, 16'hFF34);
        do_op("st_w_31", 1, 1, 0, 16'h0031, 16'hBEEF, 7, 16'hFF34);
        check_value("st_w_31_last_addr", 32'(r_last_wr_addr), 32'h0032);
        do_op("ld_w_31", 0, 1, 0, 16'h0031, 16'h0000, 5, 16'hBEEF);
        do_op("ld_w_31s", 0, 1, 1, 16'h0031, 16'h0000, 5, 16'hBEEF);
        do_op("ld_b_31", 0, 0, 0, 16'h0031, 16'h0000, 3, 16'h00EF);
        do_op("ld_b_32", 0, 0, 0, 16'h0032, 16'h0000, 3, 16'h00BE);
        do_op("ld_b_30", 0, 0, 0, 16'h0030, 16'h0000, 3, 16'h005A);
        do_op("ld_b_30s", 0, 0, 1, 16'h0030, 16'h0000, 3, 16'h005A);

        // Sign extension.
        do_op("st_b_40", 1, 0, 0, 16'h0040, 16'h0080, 4, 16'h005A);
        do_op("ld_b_40s", 0, 0, 1, 16'h0040, 16'h0000, 3, 16'hFF80);
        do_op("ld_b_40u", 0, 0, 0, 16'h0040, 16'h0000, 3, 16'h0080);

        // Wrap: low byte to 0xFFFF (ignored by memory), high byte to 0x0000.
        do_op("st_w_ffff", 1, 1, 0, 16'hFFFF, 16'h1234, 7, 16'h0080);
        check_value("st_w_ffff_last_addr", 32'(r_last_wr_addr), 32'h0000);
        do_op("ld_b_0000", 0, 0, 0, 16'h0000, 16'h0000, 3, 16'h0012);
        do_op("ld_w_ffff", 0, 1, 0, 16'hFFFF, 16'h0000, 5, 16'h1200);

        // Store to the upper half still completes, memory ignores it.
        do_op("st_b_9000", 1, 0, 0, 16'h9000, 16'h0077, 4, 16'h1200);
        do_op("ld_b_9000", 0, 0, 0, 16'h9000, 16'h0000, 3, 16'h0000);

        // Back-to-back loads with req_valid held.
        @(negedge clock);
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_size   = 1'b0;
        req_signed = 1'b0;
        req_addr   = 16'h0010;
        @(posedge clock); #1;
        req_addr = 16'h0040;
        for (int k = 2; k <= 3; k++) begin
            @(posedge clock); #1;
            check_value("b2b_a_resp", 32'(resp_valid), (k == 3) ? 32'd1 : 32'd0);
        end
        check_value("b2b_a_rdata", 32'(resp_rdata), 32'h00A5);
        check_value("b2b_a_ready", 32'(req_ready), 32'd1);
        @(posedge clock); #1;
        req_valid = 1'b0;
        check_value("b2b_accept", 32'(req_ready), 32'd0);
        for (int k = 2; k <= 3; k++) begin
            @(posedge clock); #1;
            check_value("b2b_b_resp", 32'(resp_valid), (k == 3) ? 32'd1 : 32'd0);
        end
        check_value("b2b_b_rdata", 32'(resp_rdata), 32'h0080);

        // Reset during WR_SETUP of a word store.
        @(negedge clock);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_size   = 1'b1;
        req_signed = 1'b0;
        req_addr   = 16'h0050;
        req_wdata  = 16'hCAFE;
        w0 = r_wr_count;
        @(posedge clock); #1;
        req_valid = 1'b0;
        check_value("rst_mid_in_setup", 32'(req_ready), 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check_value("rst_mid_ready",      32'(req_ready),  32'd1);
        check_value("rst_mid_mem_addr",   32'(mem_addr),   32'd0);
        check_value("rst_mid_mem_wdata",  32'(mem_wdata),  32'd0);
        check_value("rst_mid_mem_write",  32'(mem_write),  32'd0);
        check_value("rst_mid_resp_rdata", 32'(resp_rdata), 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(posedge clock); #1;
            check_value("rst_mid_no_resp", 32'(resp_valid), 32'd0);
        end
        check_value("rst_mid_no_write", 32'(r_wr_count - w0), 32'd0);
        check_value("rst_mid_mem50", 32'(r_mem[16'h0050]), 32'd0);

        // Unit is usable again after the abort.
        do_op("ld_b_31_post", 0, 0, 0, 16'h0031, 16'h0000, 3, 16'h00EF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
